alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control sequencer that issues work to the combinational ALU. It drives the ALU's OP and Im inputs and register-file addresses, and consumes the ALU's Branch flag.
- Fetches 9-bit instructions over a valid/request handshake, decodes them, and runs one EXEC cycle per instruction.
- Sits between instruction memory, register file, branch LUT and ALU.

Parameters:
- PC_W, 10, program counter / instruction address width
- PERF_W, 16, width of optional performance counters

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- Start  in  1  one-cycle pulse: begin execution at PC 0
- InstReq  out  1  fetch request, high throughout FETCH
- InstAddr  out  PC_W  fetch address (= PC)
- InstValid  in  1  instruction memory returns InstData this cycle
- InstData  in  9  instruction word
- OP  out  4  ALU opcode
- Im  out  3  ALU immediate / shift amount
- RegAddrA  out  2  register-file read port A (ALU InputA)
- RegAddrB  out  2  register-file read port B (ALU InputB)
- RegWrEn  out  1  register-file write enable, write data = ALU Out
- RegWrAddr  out  2  write address
- Branch  in  1  ALU branch flag
- BranchIdx  out  3  index into branch-target LUT
- BranchTarget  in  PC_W  LUT result for BranchIdx
- Done  out  1  high while HALTED

Behaviour:
- Instruction format: [8:5] opcode, [4:3] rA (also rd), [2:1] rB, [2:0] Im.
- Opcode map: 0 ADD, 1 ADDI, 2 LSH, 3 RSH, 4 AND, 5 OR, 6 NEG, 7 GEQ, 8 EQ, 9 NEQ, 10 BNZ, 11-14 NOP, 15 HALT.
- States: IDLE, FETCH, EXEC, HALTED.
- On reset:
  - state=IDLE, PC=0, IR=0.
  - All outputs 0: InstReq, InstAddr, OP, Im, RegAddrA/B, RegWrEn, RegWrAddr, BranchIdx, Done.
- IDLE:
  - Start=1 -> FETCH, PC<=0.
  - Otherwise stay.
- FETCH:
  - InstReq=1, InstAddr=PC.
  - At a rising edge with InstValid=1: IR<=InstData, go to EXEC.
  - Otherwise wait indefinitely.
  - Minimum fetch latency is 1 cycle (InstValid may be high in the first FETCH cycle).
- EXEC (exactly 1 cycle):
  - Outputs decode combinationally from IR: OP=IR[8:5], Im=IR[2:0], RegAddrA=IR[4:3], RegAddrB=IR[2:1], RegWrAddr=IR[4:3].
  - RegWrEn=1 for opcodes 0-9 only.
  - BNZ: BranchIdx=IR[2:0]. If Branch=1, PC<=BranchTarget; otherwise PC<=PC+1.
  - All other opcodes: PC<=PC+1.
  - Next state is FETCH, or HALTED for opcode 15 (PC unchanged).
- Outside EXEC: OP, Im, RegAddr*, RegWrAddr and BranchIdx are 0, and RegWrEn=0.
- HALTED:
  - Done=1.
  - Start=1 -> FETCH with PC<=0, Done drops in the same cycle the state leaves HALTED.
- PC arithmetic is modulo 2^PC_W: PC=2^PC_W-1 increments to 0 with no flag.
- Start is ignored in FETCH/EXEC. InstValid is ignored outside FETCH.
- Throughput: 1 instruction per (fetch latency + 1) cycles.
- Reset asserted mid-FETCH/EXEC aborts immediately. No register write occurs after the reset edge.

Optional Feature:
- ALU_SEQ_PERF_EN defined:
  - Adds outputs PerfCycles and PerfInstr (PERF_W each), reset to 0 and cleared on an accepted Start.
  - PerfCycles increments every cycle in FETCH or EXEC.
  - PerfInstr increments on each EXEC cycle, HALT included.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, Start pulse, memory returns ADDI r1,#5 (9'b0001_01_101) with 1-cycle InstValid -> EXEC cycle 2 after Start shows OP=1, Im=5, RegAddrA=1, RegWrEn=1, RegWrAddr=1; then FETCH at InstAddr=1.
- BNZ idx 3 (9'b1010_10_011), Branch=1, BranchTarget=40 -> BranchIdx=3, RegWrEn=0, next InstAddr=40. Same instruction with Branch=0 -> next InstAddr=PC+1.
- InstValid held low 4 cycles in FETCH -> InstReq stays 1, InstAddr stable, no EXEC. Valid on the 5th cycle -> EXEC the next cycle.
- HALT (9'b1111_00_000) -> Done=1 and stays 1; InstReq=0. Start -> Done=0, InstAddr=0.
- Reset dropped to 0 during an EXEC of ADD -> RegWrEn=0 immediately, all outputs 0, IDLE. Start ignored while in FETCH.
- Preload PC=1023 path via branch to target 1023 followed by NOP -> next InstAddr=0. With ALU_SEQ_PERF_EN, 3 instructions at 1-cycle fetch -> PerfInstr=3, PerfCycles=6.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the sequencer's fetch, decode/ALU, register-file,
// branch-LUT and start/done signals.
// The master modport is the sequencer side; the slave modport is the
// memory/ALU/register-file side.
// Optional macro ALU_SEQ_PERF_EN adds the PerfCycles/PerfInstr counter outputs.
interface alu_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int PERF_W = 16
);
    logic              Start;
    logic              InstReq;
    logic [PC_W-1:0]   InstAddr;
    logic              InstValid;
    logic [8:0]        InstData;
    logic [3:0]        OP;
    logic [2:0]        Im;
    logic [1:0]        RegAddrA;
    logic [1:0]        RegAddrB;
    logic              RegWrEn;
    logic [1:0]        RegWrAddr;
    logic              Branch;
    logic [2:0]        BranchIdx;
    logic [PC_W-1:0]   BranchTarget;
    logic              Done;
`ifdef ALU_SEQ_PERF_EN
    logic [PERF_W-1:0] PerfCycles;
    logic [PERF_W-1:0] PerfInstr;
`endif

    if (PC_W < 1 || PERF_W < 1) begin : g_bad_width
        $error("alu_sequencer_if: PC_W and PERF_W must be positive");
    end

    modport master (
        input  Start, InstValid, InstData, Branch, BranchTarget,
        output InstReq, InstAddr, OP, Im, RegAddrA, RegAddrB,
               RegWrEn, RegWrAddr, BranchIdx, Done
`ifdef ALU_SEQ_PERF_EN
        , output PerfCycles, PerfInstr
`endif
    );

    modport slave (
        output Start, InstValid, InstData, Branch, BranchTarget,
        input  InstReq, InstAddr, OP, Im, RegAddrA, RegAddrB,
               RegWrEn, RegWrAddr, BranchIdx, Done
`ifdef ALU_SEQ_PERF_EN
        , input PerfCycles, PerfInstr
`endif
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle IDLE/FETCH/EXEC/HALTED control sequencer that
// fetches 9-bit instructions and drives the combinational ALU, the register
// file and the branch-target LUT. Each instruction takes one EXEC cycle.
// Optional macro ALU_SEQ_PERF_EN adds saturating cycle/instruction counters.
module alu_sequencer #(
    parameter int PC_W   = 10,
    parameter int PERF_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    alu_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OPC_LAST_WR = 4'd9;
    localparam logic [3:0] OPC_BNZ     = 4'd10;
    localparam logic [3:0] OPC_HALT    = 4'd15;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [8:0]      r_ir, w_ir_nxt;
    logic [3:0]      w_opc;

    if (PC_W < 1 || PERF_W < 1) begin : g_bad_width
        $error("alu_sequencer: PC_W and PERF_W must be positive");
    end

    assign w_opc = r_ir[8:5];

    // Architectural state: FSM state, program counter and instruction register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    // Next-state logic and outputs; decode outputs are only non-zero in EXEC.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        bus.InstReq   = 1'b0;
        bus.InstAddr  = r_pc;
        bus.OP        = '0;
        bus.Im        = '0;
        bus.RegAddrA  = '0;
        bus.RegAddrB  = '0;
        bus.RegWrEn   = 1'b0;
        bus.RegWrAddr = '0;
        bus.BranchIdx = '0;
        bus.Done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = '0;
                end
            end
            ST_FETCH: begin
                bus.InstReq = 1'b1;
                if (bus.InstValid) begin
                    w_ir_nxt    = bus.InstData;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.OP        = w_opc;
                bus.Im        = r_ir[2:0];
                bus.RegAddrA  = r_ir[4:3];
                bus.RegAddrB  = r_ir[2:1];
                bus.RegWrAddr = r_ir[4:3];
                bus.RegWrEn   = (w_opc <= OPC_LAST_WR);
                if (w_opc == OPC_BNZ) begin
                    bus.BranchIdx = r_ir[2:0];
                end
                if (w_opc == OPC_HALT) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_FETCH;
                    // PC wraps modulo 2^PC_W with no flag.
                    if (w_opc == OPC_BNZ && bus.Branch) begin
                        w_pc_nxt = bus.BranchTarget;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                bus.Done = 1'b1;
                if (bus.Start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_PERF_EN
    logic [PERF_W-1:0] r_perf_cyc;
    logic [PERF_W-1:0] r_perf_ins;
    logic              w_start_acc;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    assign w_start_acc = bus.Start && (r_state == ST_IDLE || r_state == ST_HALTED);

    // Performance counters: busy cycles and executed instructions, saturating.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_perf_cyc <= '0;
            r_perf_ins <= '0;
        end else if (w_start_acc) begin
            r_perf_cyc <= '0;
            r_perf_ins <= '0;
        end else begin
            if (r_state == ST_FETCH || r_state == ST_EXEC) begin
                r_perf_cyc <= sat_inc(r_perf_cyc);
            end
            if (r_state == ST_EXEC) begin
                r_perf_ins <= sat_inc(r_perf_ins);
            end
        end
    end

    assign bus.PerfCycles = r_perf_cyc;
    assign bus.PerfInstr  = r_perf_ins;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven directed vectors, hand-written reset/halt
// sequences and a randomized instruction stream checked against an
// instruction-level reference model.
module tb_alu_sequencer;
    localparam int PC_W   = 10;
    localparam int PERF_W = 16;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    alu_sequencer_if #(.PC_W(PC_W), .PERF_W(PERF_W)) bus ();

    alu_sequencer #(.PC_W(PC_W), .PERF_W(PERF_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Branch-target LUT answers whatever index the sequencer presents.
    logic [PC_W-1:0] lut [8];
    assign bus.BranchTarget = lut[bus.BranchIdx];

    typedef struct {
        logic [8:0]      instr;
        int              lat;
        logic            br;
        logic [PC_W-1:0] tgt;
        logic [3:0]      op;
        logic [2:0]      im;
        logic [1:0]      ra;
        logic [1:0]      rb;
        logic            we;
        logic [2:0]      bidx;
        logic [PC_W-1:0] next_pc;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PC_W-1:0] exp_pc;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_InstReq"},   32'(bus.InstReq),   0);
        check({tag, "_InstAddr"},  32'(bus.InstAddr),  0);
        check({tag, "_OP"},        32'(bus.OP),        0);
        check({tag, "_Im"},        32'(bus.Im),        0);
        check({tag, "_RegAddrA"},  32'(bus.RegAddrA),  0);
        check({tag, "_RegAddrB"},  32'(bus.RegAddrB),  0);
        check({tag, "_RegWrEn"},   32'(bus.RegWrEn),   0);
        check({tag, "_RegWrAddr"}, 32'(bus.RegWrAddr), 0);
        check({tag, "_BranchIdx"}, 32'(bus.BranchIdx), 0);
        check({tag, "_Done"},      32'(bus.Done),      0);
    endtask

    // Reference model: instruction fields by plain arithmetic, next PC from the ISA rules.
    function automatic vec_t model(input logic [8:0] ins, input int lat, input logic br,
                                   input logic [PC_W-1:0] pc);
        vec_t v;
        int   opc;
        opc    = int'(ins) / 32;
        v.instr = ins;
        v.lat  = lat;
        v.br   = br;
        v.tgt  = lut[int'(ins) % 8];
        v.op   = 4'(opc);
        v.im   = 3'(int'(ins) % 8);
        v.ra   = 2'((int'(ins) / 8) % 4);
        v.rb   = 2'((int'(ins) / 2) % 4);
        v.we   = (opc <= 9);
        v.bidx = (opc == 10) ? 3'(int'(ins) % 8) : 3'd0;
        if (opc == 15)
            v.next_pc = pc;
        else if (opc == 10 && br)
            v.next_pc = v.tgt;
        else
            v.next_pc = PC_W'((int'(pc) + 1) % (1 << PC_W));
        return v;
    endfunction

    // Called at a falling edge with the sequencer in FETCH at exp_pc.
    task automatic exec_one(input vec_t v);
        for (int k = 0; k < v.lat; k++) begin
            check("stall_req",  32'(bus.InstReq),  1);
            check("stall_addr", 32'(bus.InstAddr), 32'(exp_pc));
            check("stall_wren", 32'(bus.RegWrEn),  0);
            bus.InstValid = 1'b0;
            bus.InstData  = 9'($urandom);
            bus.Branch    = 1'($urandom);
            bus.Start     = (k == 0);
            @(negedge Clk);
            bus.Start = 1'b0;
        end
        check("fetch_req",  32'(bus.InstReq),  1);
        check("fetch_addr", 32'(bus.InstAddr), 32'(exp_pc));
        bus.InstValid = 1'b1;
        bus.InstData  = v.instr;
        @(negedge Clk);
        bus.InstValid = 1'b0;
        bus.InstData  = 9'($urandom);
        check("exec_OP",        32'(bus.OP),        32'(v.op));
        check("exec_Im",        32'(bus.Im),        32'(v.im));
        check("exec_RegAddrA",  32'(bus.RegAddrA),  32'(v.ra));
        check("exec_RegAddrB",  32'(bus.RegAddrB),  32'(v.rb));
        check("exec_RegWrEn",   32'(bus.RegWrEn),   32'(v.we));
        check("exec_RegWrAddr", 32'(bus.RegWrAddr), 32'(v.ra));
        check("exec_BranchIdx", 32'(bus.BranchIdx), 32'(v.bidx));
        check("exec_InstReq",   32'(bus.InstReq),   0);
        check("exec_Done",      32'(bus.Done),      0);
        bus.Branch = v.br;
        @(negedge Clk);
        bus.Branch = 1'($urandom);
        if (v.op == 4'd15) begin
            check("halt_done", 32'(bus.Done),    1);
            check("halt_req",  32'(bus.InstReq), 0);
        end else begin
            check("next_req",  32'(bus.InstReq), 1);
            check("next_done", 32'(bus.Done),    0);
        end
        check("next_addr", 32'(bus.InstAddr), 32'(v.next_pc));
        exp_pc = v.next_pc;
    endtask

    // Called at a falling edge in HALTED: holds, then restarts at PC 0.
    task automatic halt_hold_restart();
        for (int k = 0; k < 2; k++) begin
            bus.InstValid = 1'($urandom);
            bus.InstData  = 9'($urandom);
            @(negedge Clk);
            check("hold_done", 32'(bus.Done),    1);
            check("hold_req",  32'(bus.InstReq), 0);
        end
        bus.InstValid = 1'b0;
        bus.Start     = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("restart_done", 32'(bus.Done),     0);
        check("restart_addr", 32'(bus.InstAddr), 0);
        check("restart_req",  32'(bus.InstReq),  1);
        exp_pc = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //            instr           lat br tgt   op  im ra rb we bidx next
        tbl[0] = '{9'b0001_01_101,   0, 0, 0,    1,  5, 1, 2, 1, 0,   1};
        tbl[1] = '{9'b1010_10_011,   0, 1, 40,   10, 3, 2, 1, 0, 3,   40};
        tbl[2] = '{9'b1010_10_011,   0, 0, 40,   10, 3, 2, 1, 0, 3,   41};
        tbl[3] = '{9'b0000_11_010,   4, 0, 0,    0,  2, 3, 1, 1, 0,   42};
        tbl[4] = '{9'b1001_00_111,   1, 1, 0,    9,  7, 0, 3, 1, 0,   43};
        tbl[5] = '{9'b1010_00_101,   0, 1, 1023, 10, 5, 0, 2, 0, 5,   1023};
        tbl[6] = '{9'b1011_00_000,   0, 1, 0,    11, 0, 0, 0, 0, 0,   0};
        tbl[7] = '{9'b1110_11_110,   2, 0, 0,    14, 6, 3, 3, 0, 0,   1};
        tbl[8] = '{9'b1111_00_000,   0, 0, 0,    15, 0, 0, 0, 0, 0,   1};

        for (int i = 0; i < 8; i++) lut[i] = '0;
        bus.Start     = 1'b0;
        bus.InstValid = 1'b0;
        bus.InstData  = '0;
        bus.Branch    = 1'b0;
        exp_pc        = '0;

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b1;
        @(negedge Clk);
        check("idle_req",  32'(bus.InstReq), 0);
        check("idle_done", 32'(bus.Done),    0);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].op == 4'd10) lut[tbl[i].bidx] = tbl[i].tgt;
            exec_one(tbl[i]);
        end
        halt_hold_restart();

        // Reset asserted during EXEC of ADD
        bus.InstValid = 1'b1;
        bus.InstData  = 9'b0000_01_100;
        @(negedge Clk);
        bus.InstValid = 1'b0;
        check("rst_exec_wren", 32'(bus.RegWrEn), 1);
        #2 Reset = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_idle_req",  32'(bus.InstReq), 0);
        check("rst_idle_done", 32'(bus.Done),    0);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        exp_pc = '0;

        // Randomized instruction stream against the model
        for (int i = 0; i < 8; i++) lut[i] = PC_W'($urandom);
        for (int i = 0; i < 300; i++) begin
            lut[$urandom % 8] = PC_W'($urandom);
            v = model(9'($urandom), int'($urandom % 4), 1'($urandom), exp_pc);
            exec_one(v);
            if (v.op == 4'd15) halt_hold_restart();
        end

`ifdef ALU_SEQ_PERF_EN
        // Performance counters: 3 instructions at 1-cycle fetch
        Reset = 1'b0;
        @(negedge Clk);
        check("perf_rst_cyc", 32'(bus.PerfCycles), 0);
        check("perf_rst_ins", 32'(bus.PerfInstr),  0);
        Reset = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        exp_pc = '0;
        exec_one(model(9'b0000_01_010, 0, 1'b0, exp_pc));
        exec_one(model(9'b1100_00_000, 0, 1'b0, exp_pc));
        exec_one(model(9'b1111_00_000, 0, 1'b0, exp_pc));
        check("perf_instr",  32'(bus.PerfInstr),  3);
        check("perf_cycles", 32'(bus.PerfCycles), 6);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("perf_clr_cyc", 32'(bus.PerfCycles), 0);
        check("perf_clr_ins", 32'(bus.PerfInstr),  0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
